jkc_ctrl: RTL and testbench



---
 rtl/jkc_ctrl.sv | 131 +++++++++++++
 tb/tb_jkc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jkc_ctrl.sv
// Command-driven sequencer for the JK counter: LOAD/UP/DOWN/NOP commands over valid/ready,
// stepping a count register one step per clock towards a target with done/abort/wrap reporting.
module jkc_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             wrap
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic             dir_q;      // 1 = counting down
    logic             aborted_q;
    logic             wrap_q;

    logic             accept;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign step_val  = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    assign step_wrap = dir_q ? (count_q == '0) : (count_q == '1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((cmd_op == OP_LOAD) || (cmd_op == OP_NOP) || (cmd_arg == count_q)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort || (step_val == target_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Count datapath and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            target_q  <= '0;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_LOAD: count_q <= cmd_arg;
                            OP_UP: begin
                                target_q <= cmd_arg;
                                dir_q    <= 1'b0;
                            end
                            OP_DOWN: begin
                                target_q <= cmd_arg;
                                dir_q    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort wins over a pending step, including the final one
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end else begin
                        count_q <= step_val;
                        wrap_q  <= step_wrap;
                    end
                end
                S_DONE:  aborted_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        count     = count_q;
        aborted   = aborted_q;
        wrap      = wrap_q;
    end

endmodule

// File: tb/tb_jkc_ctrl.sv
// Self-checking bench for jkc_ctrl: a cycle-level reference model pushes expected per-cycle
// outputs to a scoreboard queue as each command is driven; each test pops and compares.
module tb_jkc_ctrl;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef struct packed {
        logic [2:0] count;
        logic       busy;
        logic       done;
        logic       aborted;
        logic       wrap;
        logic       ready;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_arg;
    logic       abort;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb[$];
    logic [2:0] m_count = 3'd0;

    jkc_ctrl #(.WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .count(count),
        .busy(busy), .done(done), .aborted(aborted), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = '{count: count, busy: busy, done: done, aborted: aborted, wrap: wrap, ready: cmd_ready};
        return o;
    endfunction

    function automatic obs_t mk(logic [2:0] c, logic b, logic d, logic a, logic w, logic r);
        obs_t o;
        o = '{count: c, busy: b, done: d, aborted: a, wrap: w, ready: r};
        return o;
    endfunction

    // Reference model: expected outputs sampled after the accepting edge and each edge after it.
    // abort_k >= 0 means abort is raised after that many steps have been taken.
    function automatic void push_cmd(logic [1:0] op, logic [2:0] arg, int abort_k);
        logic [2:0] c;
        logic       up;
        logic       w;
        logic       ab;
        int         k;
        c  = m_count;
        ab = 1'b0;
        if (op == OP_LOAD) begin
            c = arg;
            sb.push_back(mk(c, 1, 1, 0, 0, 0));
        end else if (op == OP_NOP || arg == c) begin
            sb.push_back(mk(c, 1, 1, 0, 0, 0));
        end else begin
            up = (op == OP_UP);
            sb.push_back(mk(c, 1, 0, 0, 0, 0));
            k = 0;
            while (c != arg && !ab) begin
                if (abort_k == k) begin
                    ab = 1'b1;
                    sb.push_back(mk(c, 1, 1, 1, 0, 0));
                end else begin
                    w = up ? (c == 3'd7) : (c == 3'd0);
                    c = up ? c + 3'd1 : c - 3'd1;
                    k++;
                    sb.push_back(mk(c, 1, (c == arg), 0, w, 0));
                end
            end
        end
        sb.push_back(mk(c, 0, 0, 0, 0, 1));
        m_count = c;
    endfunction

    task automatic drive_cmd(logic [1:0] op, logic [2:0] arg, int abort_k);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        push_cmd(op, arg, abort_k);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        e = mk(3'd0, 0, 0, 0, 0, 1);
        o = sample();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", o, e);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        o = sample();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", o, e);
        end
    endtask

    task automatic test_commands(string name, logic [1:0] ops[], logic [2:0] args[]);
        obs_t o;
        obs_t e;
        for (int i = 0; i < ops.size(); i++) begin
            drive_cmd(ops[i], args[i], -1);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = sample();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %b expected %b (count,busy,done,aborted,wrap,ready)",
                             name, i, o, e);
                end
                if (sb.size() > 0) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_abort();
        obs_t o;
        obs_t e;
        int   idx;
        test_commands("abort_pre", '{OP_LOAD}, '{3'd0});
        drive_cmd(OP_UP, 3'd6, 2);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort[%0d]: got %b expected %b", idx, o, e);
            end
            abort = (idx == 2);
            idx++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        abort = 1'b0;
        // abort while idle must have no effect
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = mk(m_count, 0, 0, 0, 0, 1);
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_idle[%0d]: got %b expected %b", i, o, e);
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        obs_t e;
        int   idx;
        test_commands("b2b_pre", '{OP_LOAD}, '{3'd0});
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_arg   = 3'd2;
        push_cmd(OP_UP, 3'd2, -1);
        push_cmd(OP_LOAD, 3'd7, -1);
        @(posedge clk); #1;
        // second command held while the first runs; accepted only once idle
        cmd_op  = OP_LOAD;
        cmd_arg = 3'd7;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b expected %b", idx, o, e);
            end
            if (idx == 4) cmd_valid = 1'b0;
            idx++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        obs_t o;
        obs_t e;
        test_commands("rst_pre", '{OP_LOAD}, '{3'd1});
        drive_cmd(OP_UP, 3'd6, -1);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_run[%0d]: got %b expected %b", i, o, e);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        sb.delete();
        m_count = 3'd0;
        rst_n = 1'b0;
        #1;
        e = mk(3'd0, 0, 0, 0, 0, 1);
        o = sample();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected %b", o, e);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            o = sample();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_after[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 3'd0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_commands("load",   '{OP_LOAD}, '{3'd5});
        test_commands("up",     '{OP_LOAD, OP_UP}, '{3'd2, 3'd5});
        test_commands("wrap",   '{OP_LOAD, OP_UP, OP_LOAD, OP_DOWN}, '{3'd6, 3'd1, 3'd1, 3'd6});
        test_commands("zero",   '{OP_LOAD, OP_UP, OP_NOP, OP_DOWN}, '{3'd3, 3'd3, 3'd0, 3'd3});
        test_commands("load0",  '{OP_LOAD, OP_LOAD}, '{3'd7, 3'd0});
        test_commands("full",   '{OP_UP, OP_DOWN}, '{3'd7, 3'd0});
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
